// File: rtl/ram_scan_arbiter.sv
// Arbitrates a single-port 32x4 synchronous RAM between a display scan reader
// and an edge-triggered key writer. Writes win, and each side has a one-deep pending slot.
module ram_scan_arbiter #(
  parameter int RD_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] scan_addr,
  input  logic       scan_adv,
  input  logic       wr_req,
  input  logic [4:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [3:0] ram_rdata,
  output logic [4:0] ram_addr,
  output logic       ram_wren,
  output logic [3:0] ram_wdata,
  output logic       wr_ack,
  output logic [4:0] disp_addr,
  output logic [3:0] disp_data,
  output logic       disp_valid,
  output logic [1:0] dbg_state
);
  // scan_adv is a one-cycle request pulse and wr_req is a level whose rising edge is
  // one request. Neither input has a ready: requests that arrive while the RAM is busy
  // are parked. wr_ack pulses in the single cycle the write is presented to the RAM.
  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, WR = 2'd2} state_e;

  localparam logic [1:0] LAT_LOAD = 2'(RD_LATENCY);

  state_e     state_q, state_d;
  logic [4:0] rd_addr_q, rd_addr_d;
  logic [1:0] lat_q, lat_d;
  logic       wr_prev_q, wr_prev_d;
  logic [4:0] wr_addr_q, wr_addr_d;
  logic [3:0] wr_data_q, wr_data_d;
  logic       scan_pend_q, scan_pend_d;
  logic [4:0] scan_pend_addr_q, scan_pend_addr_d;
  logic       wr_pend_q, wr_pend_d;
  logic [4:0] wr_pend_addr_q, wr_pend_addr_d;
  logic [3:0] wr_pend_data_q, wr_pend_data_d;
  logic [4:0] disp_addr_q, disp_addr_d;
  logic [3:0] disp_data_q, disp_data_d;
  logic       disp_valid_q, disp_valid_d;
  logic       wr_edge;

  assign wr_edge = wr_req & ~wr_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      rd_addr_q        <= '0;
      lat_q            <= '0;
      wr_prev_q        <= 1'b1;
      wr_addr_q        <= '0;
      wr_data_q        <= '0;
      scan_pend_q      <= 1'b0;
      scan_pend_addr_q <= '0;
      wr_pend_q        <= 1'b0;
      wr_pend_addr_q   <= '0;
      wr_pend_data_q   <= '0;
      disp_addr_q      <= '0;
      disp_data_q      <= '0;
      disp_valid_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      rd_addr_q        <= rd_addr_d;
      lat_q            <= lat_d;
      wr_prev_q        <= wr_prev_d;
      wr_addr_q        <= wr_addr_d;
      wr_data_q        <= wr_data_d;
      scan_pend_q      <= scan_pend_d;
      scan_pend_addr_q <= scan_pend_addr_d;
      wr_pend_q        <= wr_pend_d;
      wr_pend_addr_q   <= wr_pend_addr_d;
      wr_pend_data_q   <= wr_pend_data_d;
      disp_addr_q      <= disp_addr_d;
      disp_data_q      <= disp_data_d;
      disp_valid_q     <= disp_valid_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    rd_addr_d        = rd_addr_q;
    lat_d            = lat_q;
    wr_prev_d        = wr_req;
    wr_addr_d        = wr_addr_q;
    wr_data_d        = wr_data_q;
    scan_pend_d      = scan_pend_q;
    scan_pend_addr_d = scan_pend_addr_q;
    wr_pend_d        = wr_pend_q;
    wr_pend_addr_d   = wr_pend_addr_q;
    wr_pend_data_d   = wr_pend_data_q;
    disp_addr_d      = disp_addr_q;
    disp_data_d      = disp_data_q;
    disp_valid_d     = disp_valid_q;

    unique case (state_q)
      IDLE: begin
        if (wr_pend_q || wr_edge) begin
          state_d = WR;
          if (wr_pend_q) begin
            // Older parked write goes first; a fresh edge refills the freed slot.
            wr_addr_d = wr_pend_addr_q;
            wr_data_d = wr_pend_data_q;
            wr_pend_d = wr_edge;
            if (wr_edge) begin
              wr_pend_addr_d = wr_addr;
              wr_pend_data_d = wr_data;
            end
          end else begin
            wr_addr_d = wr_addr;
            wr_data_d = wr_data;
          end
          if (scan_adv) begin
            scan_pend_d      = 1'b1;
            scan_pend_addr_d = scan_addr;
          end
        end else if (scan_adv || scan_pend_q) begin
          state_d     = RD_WAIT;
          rd_addr_d   = scan_adv ? scan_addr : scan_pend_addr_q;
          lat_d       = LAT_LOAD;
          scan_pend_d = 1'b0;
        end
      end
      RD_WAIT: begin
        if (lat_q == 2'd0) begin
          state_d      = IDLE;
          disp_addr_d  = rd_addr_q;
          disp_data_d  = ram_rdata;
          disp_valid_d = 1'b1;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      WR: begin
        state_d = IDLE;
        // Keep the displayed word coherent with the RAM without issuing a re-read.
        if (disp_valid_q && (wr_addr_q == disp_addr_q)) disp_data_d = wr_data_q;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      if (scan_adv) begin
        scan_pend_d      = 1'b1;
        scan_pend_addr_d = scan_addr;
      end
      if (wr_edge && !wr_pend_q) begin
        wr_pend_d      = 1'b1;
        wr_pend_addr_d = wr_addr;
        wr_pend_data_d = wr_data;
      end
    end
  end

  assign ram_addr   = (state_q == WR) ? wr_addr_q : rd_addr_q;
  assign ram_wdata  = wr_data_q;
  assign ram_wren   = (state_q == WR);
  assign wr_ack     = (state_q == WR);
  assign disp_addr  = disp_addr_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ram_scan_arbiter.sv
// Bench for ram_scan_arbiter: one instance per read latency (1 and 2), each with its own
// RAM model, driven by the same directed stimulus and checked against a memory-level model.
module tb_ram_scan_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, preload, scan_adv, wr_req;
  logic [4:0] scan_addr, wr_addr;
  logic [3:0] wr_data;

  logic [4:0] ram_addr [2];
  logic       ram_wren [2];
  logic [3:0] ram_wdata [2];
  logic [3:0] ram_rdata [2];
  logic       wr_ack [2];
  logic [4:0] disp_addr [2];
  logic [3:0] disp_data [2];
  logic       disp_valid [2];
  logic [1:0] dbg_state [2];

  // Functional model: memory contents as the writer intends them, plus write order.
  logic [3:0] model_mem [2][32];
  logic [8:0] exp_q[$];
  int         wr_idx [2];
  int         wren_tot [2];
  int         checks = 0;
  int         errors = 0;

  function automatic logic [3:0] init_word(int i);
    if (i == 5) return 4'hA;
    if (i == 12) return 4'h1;
    return 4'((i * 5 + 1) % 16);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [3:0] mem [32];
    logic [3:0] p0, p1;

    ram_scan_arbiter #(.RD_LATENCY(g + 1)) u_dut (
      .clk(clk), .reset(reset), .scan_addr(scan_addr), .scan_adv(scan_adv),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .ram_rdata(ram_rdata[g]),
      .ram_addr(ram_addr[g]), .ram_wren(ram_wren[g]), .ram_wdata(ram_wdata[g]),
      .wr_ack(wr_ack[g]), .disp_addr(disp_addr[g]), .disp_data(disp_data[g]),
      .disp_valid(disp_valid[g]), .dbg_state(dbg_state[g])
    );

    always @(posedge clk) begin
      if (preload) begin
        for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
      end else if (ram_wren[g]) begin
        mem[ram_addr[g]] <= ram_wdata[g];
      end
      p0 <= mem[ram_addr[g]];
      p1 <= p0;
    end
    assign ram_rdata[g] = (g == 0) ? p0 : p1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input int g);
    chk("rst_ram_addr", 32'(ram_addr[g]), 32'd0);
    chk("rst_ram_wren", 32'(ram_wren[g]), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata[g]), 32'd0);
    chk("rst_wr_ack", 32'(wr_ack[g]), 32'd0);
    chk("rst_disp_addr", 32'(disp_addr[g]), 32'd0);
    chk("rst_disp_data", 32'(disp_data[g]), 32'd0);
    chk("rst_disp_valid", 32'(disp_valid[g]), 32'd0);
  endtask

  task automatic chk_disp(input string name, input int g, input logic [4:0] a, input logic [3:0] d);
    chk({name, "_addr"}, 32'(disp_addr[g]), 32'(a));
    chk({name, "_data"}, 32'(disp_data[g]), 32'(d));
    chk({name, "_valid"}, 32'(disp_valid[g]), 32'd1);
  endtask

  // Per-cycle compare against the model: every write must be the next one the writer
  // asked for, and a valid display must always show the current memory word.
  always @(negedge clk) begin
    if (!reset) begin
      for (int g = 0; g < 2; g++) begin
        chk("wr_ack_vs_wren", 32'(wr_ack[g]), 32'(ram_wren[g]));
        if (disp_valid[g])
          chk("disp_vs_model", 32'(disp_data[g]), 32'(model_mem[g][disp_addr[g]]));
        if (ram_wren[g]) begin
          wren_tot[g]++;
          if (wr_idx[g] < exp_q.size()) begin
            chk("write_addr_data", 32'({ram_addr[g], ram_wdata[g]}), 32'(exp_q[wr_idx[g]]));
            model_mem[g][exp_q[wr_idx[g]][8:4]] = exp_q[wr_idx[g]][3:0];
            wr_idx[g]++;
          end else begin
            chk("unexpected_write", 32'(ram_wren[g]), 32'd0);
          end
        end
      end
    end
  end

  int base [2];

  initial begin
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 32; i++) model_mem[g][i] = init_word(i);
      wr_idx[g]   = 0;
      wren_tot[g] = 0;
    end
    reset = 1'b1; preload = 1'b1; scan_adv = 1'b0; wr_req = 1'b0;
    scan_addr = '0; wr_addr = '0; wr_data = '0;
    step();
    preload = 1'b0;
    step(2);
    for (int g = 0; g < 2; g++) chk_all_zero(g);
    reset = 1'b0;
    step(2);

    // Read addr 5: visible after edge t+2 (latency 1) and t+3 (latency 2).
    scan_addr = 5'd5; scan_adv = 1'b1;
    step();
    scan_adv = 1'b0;
    step();
    chk("rd5_early_l1", 32'(disp_valid[0]), 32'd0);
    step();
    chk_disp("rd5_l1", 0, 5'd5, 4'hA);
    chk("rd5_early_l2", 32'(disp_valid[1]), 32'd0);
    step();
    chk_disp("rd5_l2", 1, 5'd5, 4'hA);
    step(3);

    // Held-high key: exactly one write of 7 to addr 3.
    for (int g = 0; g < 2; g++) base[g] = wren_tot[g];
    wr_addr = 5'd3; wr_data = 4'h7; wr_req = 1'b1; exp_q.push_back({5'd3, 4'h7});
    step();
    chk("wr3_wren", 32'(ram_wren[0]), 32'd1);
    chk("wr3_ack", 32'(wr_ack[0]), 32'd1);
    chk("wr3_addr", 32'(ram_addr[0]), 32'd3);
    chk("wr3_wdata", 32'(ram_wdata[0]), 32'd7);
    step(9);
    wr_req = 1'b0;
    step(2);
    for (int g = 0; g < 2; g++) chk("wr3_count", 32'(wren_tot[g] - base[g]), 32'd1);

    // Simultaneous write and read of addr 9: write first, read sees new data.
    wr_addr = 5'd9; wr_data = 4'h2; wr_req = 1'b1; exp_q.push_back({5'd9, 4'h2});
    scan_addr = 5'd9; scan_adv = 1'b1;
    step();
    scan_adv = 1'b0; wr_req = 1'b0;
    step(8);
    for (int g = 0; g < 2; g++) chk_disp("wr_then_rd9", g, 5'd9, 4'h2);

    // Write bypass onto the displayed word at addr 12.
    scan_addr = 5'd12; scan_adv = 1'b1;
    step();
    scan_adv = 1'b0;
    step(6);
    for (int g = 0; g < 2; g++) chk_disp("rd12", g, 5'd12, 4'h1);
    wr_addr = 5'd12; wr_data = 4'hE; wr_req = 1'b1; exp_q.push_back({5'd12, 4'hE});
    step();
    wr_req = 1'b0;
    chk("byp12_before", 32'(disp_data[0]), 32'h1);
    step();
    for (int g = 0; g < 2; g++) chk_disp("byp12", g, 5'd12, 4'hE);
    step(3);

    // Scans while busy: newest pending address wins.
    scan_addr = 5'd20; scan_adv = 1'b1;
    step();
    scan_addr = 5'd21;
    step();
    scan_addr = 5'd22;
    step();
    scan_adv = 1'b0;
    step(10);
    for (int g = 0; g < 2; g++) chk_disp("newest22", g, 5'd22, init_word(22));

    // Write arriving during a read is parked, then bypasses onto the display.
    scan_addr = 5'd20; scan_adv = 1'b1;
    step();
    scan_adv = 1'b0;
    wr_addr = 5'd20; wr_data = 4'h5; wr_req = 1'b1; exp_q.push_back({5'd20, 4'h5});
    step();
    wr_req = 1'b0;
    step(10);
    for (int g = 0; g < 2; g++) chk_disp("pend_wr20", g, 5'd20, 4'h5);

    // Full scroll sweep 0..31 then 0, one scan every 4 cycles.
    for (int k = 0; k < 33; k++) begin
      scan_addr = 5'(k % 32); scan_adv = 1'b1;
      step();
      scan_adv = 1'b0;
      step(2);
      chk("sweep_l1_addr", 32'(disp_addr[0]), 32'(k % 32));
      step();
      chk("sweep_l2_addr", 32'(disp_addr[1]), 32'(k % 32));
      chk("sweep_l2_valid", 32'(disp_valid[1]), 32'd1);
    end
    step(3);

    // Reset one cycle into a read with the key held through it: no capture, no write.
    for (int g = 0; g < 2; g++) base[g] = wren_tot[g];
    scan_addr = 5'd7; scan_adv = 1'b1;
    step();
    scan_adv = 1'b0;
    step();
    reset = 1'b1; wr_req = 1'b1; wr_addr = 5'd7; wr_data = 4'h3;
    step();
    for (int g = 0; g < 2; g++) chk_all_zero(g);
    step();
    reset = 1'b0;
    step(6);
    for (int g = 0; g < 2; g++) begin
      chk("rst_no_write", 32'(wren_tot[g] - base[g]), 32'd0);
      chk("rst_no_capture", 32'(disp_valid[g]), 32'd0);
    end
    wr_req = 1'b0;
    step(2);

    for (int g = 0; g < 2; g++) chk("all_writes_seen", 32'(wr_idx[g]), 32'(exp_q.size()));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
